// File: rtl/pipelined_cla_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_cla_pkg
//   Shared definitions for the pipelined carry-lookahead adder/subtractor:
//   default geometry, operation encoding, per-stage control word and
//   elaboration-time configuration helpers.
// -----------------------------------------------------------------------------
package pipelined_cla_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_GROUP  = 4;
  localparam int unsigned DEF_STAGES = 2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Control word travelling down the pipe alongside each beat.
  typedef struct packed {
    logic valid;
    logic sub;
    logic sat;
    logic carry;
  } stage_ctl_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Geometry must divide evenly: WIDTH into STAGES slices, each slice into
  // whole GROUP-bit lookahead groups.
  function automatic logic cfg_ok(input int unsigned w, input int unsigned g,
                                  input int unsigned s);
    if (s == 0 || g == 0 || w == 0) return 1'b0;
    if ((w % s) != 0)               return 1'b0;
    if (((w / s) % g) != 0)         return 1'b0;
    return (s <= (w / g));
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_group.sv
// -----------------------------------------------------------------------------
// cla_group
//   GROUP-bit combinational carry-lookahead block.
//   Ports:
//     x, y  [GROUP]  operand bits (y already inverted for subtraction)
//     ci             carry into the group
//     s     [GROUP]  sum bits
//     g, p           group generate / propagate (independent of ci)
//     co             carry out of the group
// -----------------------------------------------------------------------------
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] x,
  input  logic [GROUP-1:0] y,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             g,
  output logic             p,
  output logic             co
);

  logic [GROUP-1:0] w_bg;
  logic [GROUP-1:0] w_bp;
  logic [GROUP:0]   w_c;

  assign w_bg = x & y;
  assign w_bp = x ^ y;

  // Group G/P kept in a block that never reads ci, so the slice-level carry
  // chain built from g/p has no combinational path back through ci.
  always_comb begin
    g = 1'b0;
    for (int unsigned i = 0; i < GROUP; i++) g = w_bg[i] | (w_bp[i] & g);
  end

  assign p = &w_bp;

  // Each carry is the flat sum-of-products over all lower bits plus ci.
  always_comb begin
    logic v_term;
    logic v_prop;
    v_term = 1'b0;
    v_prop = 1'b1;
    w_c    = '0;
    w_c[0] = ci;
    for (int unsigned i = 0; i < GROUP; i++) begin
      v_term = 1'b0;
      v_prop = 1'b1;
      for (int unsigned j = i + 1; j > 0; j--) begin
        v_term = v_term | (w_bg[j-1] & v_prop);
        v_prop = v_prop & w_bp[j-1];
      end
      w_c[i+1] = v_term | (v_prop & ci);
    end
  end

  assign s  = w_bp ^ w_c[GROUP-1:0];
  assign co = w_c[GROUP];

endmodule

// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
//   Skewed-pipeline carry-lookahead adder/subtractor. The operands are cut
//   into STAGES slices of WIDTH/STAGES bits; slice k is summed in stage k
//   from GROUP-bit lookahead groups, and its carry-out is registered into
//   stage k+1. Latency is STAGES cycles, throughput one beat per cycle.
//   Optional saturation: define PIPELINED_CLA_SAT_EN to add the sat input.
//   Ports:
//     clk, rst              clock, asynchronous active-high reset
//     in_valid / in_ready   operand handshake (in_ready = pipe may advance)
//     a, b, cin, sub        operands; sub=1 computes a-b (cin ignored)
//     sat                   (PIPELINED_CLA_SAT_EN only) clamp on overflow
//     out_valid / out_ready result handshake with backpressure
//     sum, cout, ovf        result, carry-out, signed overflow
// -----------------------------------------------------------------------------
module pipelined_cla_adder
  import pipelined_cla_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned GROUP  = DEF_GROUP,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef PIPELINED_CLA_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (!cfg_ok(WIDTH, GROUP, STAGES)) begin : g_cfg_err
    $error("pipelined_cla_adder: illegal WIDTH/GROUP/STAGES combination");
  end

  localparam int unsigned SW = WIDTH / STAGES;
  localparam int unsigned NG = SW / GROUP;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             w_en;
  logic             w_sat_in;

`ifdef PIPELINED_CLA_SAT_EN
  assign w_sat_in = sat;
`else
  assign w_sat_in = 1'b0;
`endif

  // Whole pipe advances in lockstep; a stalled output freezes every stage.
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned REM  = WIDTH - k * SW;  // operand bits still to sum
    localparam int unsigned DONE = k * SW;          // sum bits already complete

    logic [REM-1:0]       w_x;
    logic [REM-1:0]       w_y;
    stage_ctl_t           w_ctl;
    logic [SW-1:0]        w_s;
    logic [NG:0]          w_c;
    logic [NG-1:0]        w_g;
    logic [NG-1:0]        w_p;
    logic [NG-1:0]        w_co_unused;  // same value as w_c[j+1]
    logic [DONE+SW-1:0]   w_ps_n;

    if (k == 0) begin : g_src
      assign w_x    = a;
      assign w_y    = (sub == OP_SUB) ? ~b : b;
      assign w_ctl  = '{valid: in_valid, sub: sub, sat: w_sat_in,
                        carry: (sub == OP_SUB) ? 1'b1 : cin};
      assign w_ps_n = w_s;
    end else begin : g_src
      assign w_x    = g_stage[k-1].g_reg.r_a;
      assign w_y    = g_stage[k-1].g_reg.r_b;
      assign w_ctl  = g_stage[k-1].g_reg.r_ctl;
      assign w_ps_n = {w_s, g_stage[k-1].g_reg.r_ps};
    end

    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
        .x  (w_x[j*GROUP +: GROUP]),
        .y  (w_y[j*GROUP +: GROUP]),
        .ci (w_c[j]),
        .s  (w_s[j*GROUP +: GROUP]),
        .g  (w_g[j]),
        .p  (w_p[j]),
        .co (w_co_unused[j])
      );
    end

    // Group carries ripple group-to-group inside the slice.
    always_comb begin
      w_c    = '0;
      w_c[0] = w_ctl.carry;
      for (int unsigned j = 0; j < NG; j++) w_c[j+1] = w_g[j] | (w_p[j] & w_c[j]);
    end

    if (k < STAGES - 1) begin : g_reg
      stage_ctl_t         r_ctl;
      logic [REM-SW-1:0]  r_a;
      logic [REM-SW-1:0]  r_b;
      logic [DONE+SW-1:0] r_ps;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ctl <= '0;
          r_a   <= '0;
          r_b   <= '0;
          r_ps  <= '0;
        end else if (w_en) begin
          r_ctl <= '{valid: w_ctl.valid, sub: w_ctl.sub, sat: w_ctl.sat, carry: w_c[NG]};
          r_a   <= w_x[REM-1:SW];
          r_b   <= w_y[REM-1:SW];
          r_ps  <= w_ps_n;
        end
      end
    end else begin : g_last
      logic             w_c_msb;
      logic             w_ovf_n;
      logic [WIDTH-1:0] w_sum_n;
      logic             w_unused_ctl;

      // Carry into the MSB recovered from the MSB sum bit.
      assign w_c_msb = w_x[SW-1] ^ w_y[SW-1] ^ w_s[SW-1];
      assign w_ovf_n = w_c_msb ^ w_c[NG];

`ifdef PIPELINED_CLA_SAT_EN
      // Wrapped MSB set means the true result overflowed positive.
      always_comb begin
        w_sum_n = w_ps_n;
        if (w_ctl.sat && w_ovf_n)
          w_sum_n = w_ps_n[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                    : {1'b1, {(WIDTH-1){1'b0}}};
      end
      assign w_unused_ctl = w_ctl.sub;
`else
      assign w_sum_n      = w_ps_n;
      assign w_unused_ctl = w_ctl.sub ^ w_ctl.sat;
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_out_valid <= 1'b0;
          r_sum       <= '0;
          r_cout      <= 1'b0;
          r_ovf       <= 1'b0;
        end else if (w_en) begin
          r_out_valid <= w_ctl.valid;
          r_sum       <= w_sum_n;
          r_cout      <= w_c[NG];
          r_ovf       <= w_ovf_n;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
